// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic tile scheduler and array-level benches.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        WAIT_OUT
    } sched_state_e;

    function automatic int drain_lat(input int rows, input int cols, input int pipe_lat);
        return rows + cols + pipe_lat;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sched_beat_ctr.sv
// Loadable down-counter shared by the beat and drain phases; load wins over decrement.
module sched_beat_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign tc   = (count == W'(1));

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile sequencer: streams K operand beats per tile, waits for the array to drain, then hands off the result.
// States: IDLE wait for command | FEED stream k_len beats | DRAIN wait array latency | WAIT_OUT hold res_valid.
module systolic_tile_sched
    import systolic_pkg::*;
#(
    parameter int ROWS     = 64,
    parameter int COLS     = 64,
    parameter int PIPE_LAT = 3,
    parameter int K_MAX    = 256,
    parameter int TILE_W   = 8,
    parameter int ADDR_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    input  logic [TILE_W-1:0]          num_tiles,
    output logic                       op_rd_en,
    output logic [ADDR_W-1:0]          op_rd_addr,
    output logic                       array_en,
    output logic                       array_clr,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TILE_W-1:0]          tile_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    output logic [31:0]                perf_cycles
);

    localparam int DRAIN_LAT = drain_lat(ROWS, COLS, PIPE_LAT);
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int CNT_W     = $clog2(max_int(K_MAX, DRAIN_LAT) + 1);

    sched_state_e      state, state_nxt;
    logic [KW-1:0]     k_len_q;
    logic [TILE_W-1:0] num_tiles_q;
    logic [KW-1:0]     beat;

    logic              cnt_load, cnt_dec, cnt_zero, cnt_tc;
    logic [CNT_W-1:0]  cnt_load_val, cnt;
    logic              accept, reject, tile_adv, finish;

    sched_beat_ctr #(.W(CNT_W)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        accept       = 1'b0;
        reject       = 1'b0;
        tile_adv     = 1'b0;
        finish       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (k_len == '0 || k_len > KW'(K_MAX) || num_tiles == '0) begin
                        reject = 1'b1;
                    end else begin
                        accept       = 1'b1;
                        state_nxt    = FEED;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(k_len);
                    end
                end
            end
            FEED: begin
                cnt_dec = 1'b1;
                if (cnt_tc || cnt_zero) begin
                    state_nxt    = DRAIN;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(DRAIN_LAT);
                end
            end
            DRAIN: begin
                cnt_dec = 1'b1;
                if (cnt_tc || cnt_zero) state_nxt = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (res_ready) begin
                    if (tile_idx == num_tiles_q - TILE_W'(1)) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tile_adv     = 1'b1;
                        state_nxt    = FEED;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(k_len_q);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat index recovered from the remaining-beat count; only meaningful in FEED.
    assign beat       = k_len_q - KW'(cnt);
    assign op_rd_en   = (state == FEED);
    assign op_rd_addr = op_rd_en ? (ADDR_W'(tile_idx) * ADDR_W'(K_MAX) + ADDR_W'(beat)) : '0;
    assign res_valid  = (state == WAIT_OUT);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_q     <= '0;
            num_tiles_q <= '0;
            tile_idx    <= '0;
            perf_cycles <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            array_en    <= 1'b0;
            array_clr   <= 1'b0;
        end else begin
            done      <= finish | reject;
            cfg_err   <= reject;
            array_en  <= op_rd_en;
            array_clr <= op_rd_en && (beat == '0);
            if (accept || reject) begin
                k_len_q     <= k_len;
                num_tiles_q <= num_tiles;
                tile_idx    <= '0;
                perf_cycles <= '0;
            end else begin
                if (tile_adv) tile_idx <= tile_idx + TILE_W'(1);
                if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Directed bench for systolic_tile_sched with ROWS=COLS=4, PIPE_LAT=3, K_MAX=16 (drain 11).
module tb_systolic_tile_sched;

    localparam int K_MAX  = 16;
    localparam int TILE_W = 8;
    localparam int ADDR_W = 16;
    localparam int KW     = $clog2(K_MAX + 1);

    logic              clk, rst, start, res_ready;
    logic [KW-1:0]     k_len;
    logic [TILE_W-1:0] num_tiles;
    logic              op_rd_en, array_en, array_clr, res_valid, busy, done, cfg_err;
    logic [ADDR_W-1:0] op_rd_addr;
    logic [TILE_W-1:0] tile_idx;
    logic [31:0]       perf_cycles;

    int n_checks = 0;
    int n_errors = 0;

    systolic_tile_sched #(
        .ROWS(4), .COLS(4), .PIPE_LAT(3), .K_MAX(K_MAX), .TILE_W(TILE_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .num_tiles(num_tiles),
        .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr), .array_en(array_en), .array_clr(array_clr),
        .res_valid(res_valid), .res_ready(res_ready), .tile_idx(tile_idx), .busy(busy),
        .done(done), .cfg_err(cfg_err), .perf_cycles(perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int nt;
        int delay;
        int disturb;
        int exp_err;
        int exp_done_cyc;
        int exp_perf;
        int exp_rd;
        int exp_clr;
        int exp_valid;
        int exp_first_valid;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s (vec %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    function automatic int outs_active();
        return (op_rd_en || op_rd_addr != '0 || array_en || array_clr || res_valid ||
                tile_idx != '0 || busy || done || cfg_err || perf_cycles != '0) ? 1 : 0;
    endfunction

    // Issues one command in the current cycle (cycle 0) and tracks it until done.
    task automatic run_cmd(input vec_t v, input int id);
        int cyc, rd, en, clr, vld, errs, dn, bsy, bad, overlap, first_valid, done_cyc, perf_at_done, vwait;
        int exp_addr;
        rd = 0; en = 0; clr = 0; vld = 0; errs = 0; dn = 0; bsy = 0; bad = 0; overlap = 0;
        first_valid = -1; done_cyc = -1; perf_at_done = -1; vwait = 0;
        start     = 1'b1;
        k_len     = KW'(v.k);
        num_tiles = TILE_W'(v.nt);
        res_ready = 1'b0;
        tick();
        start     = 1'b0;
        k_len     = ~k_len;
        num_tiles = ~num_tiles;
        cyc = 1;
        while (done_cyc < 0 && cyc <= 400) begin
            if (op_rd_en) begin
                if (v.k > 0) begin
                    exp_addr = ((rd / v.k) * K_MAX + (rd % v.k)) & 16'hFFFF;
                    if (int'(op_rd_addr) != exp_addr) bad++;
                    if (int'(tile_idx) != rd / v.k) bad++;
                end
                rd++;
            end
            if (array_en)  en++;
            if (array_clr) clr++;
            if (res_valid) begin
                vld++;
                if (first_valid < 0) first_valid = cyc;
                if (op_rd_en || array_en) overlap++;
            end
            if (cfg_err) errs++;
            if (busy)    bsy++;
            if (done) begin
                dn++;
                done_cyc     = cyc;
                perf_at_done = int'(perf_cycles);
            end
            if (res_valid) begin
                res_ready = (vwait >= v.delay);
                if (res_ready) vwait = 0;
                else           vwait++;
            end else begin
                res_ready = (cyc % 3 == 0);
            end
            if (cyc == v.disturb) begin
                start     = 1'b1;
                k_len     = KW'(2);
                num_tiles = TILE_W'(3);
            end else begin
                start = 1'b0;
            end
            if (done_cyc < 0) begin
                tick();
                cyc++;
            end
        end
        start     = 1'b0;
        res_ready = 1'b0;
        chk("done_seen",      id, (done_cyc >= 0) ? 1 : 0, 1);
        chk("done_cycle",     id, done_cyc,     v.exp_done_cyc);
        chk("done_count",     id, dn,           1);
        chk("cfg_err_count",  id, errs,         v.exp_err);
        chk("perf_at_done",   id, perf_at_done, v.exp_perf);
        chk("busy_cycles",    id, bsy,          v.exp_perf);
        chk("rd_beats",       id, rd,           v.exp_rd);
        chk("en_beats",       id, en,           v.exp_rd);
        chk("clr_count",      id, clr,          v.exp_clr);
        chk("valid_cycles",   id, vld,          v.exp_valid);
        chk("first_valid",    id, first_valid,  v.exp_first_valid);
        chk("addr_tile_errs", id, bad,          0);
        chk("en_during_out",  id, overlap,      0);
    endtask

    initial begin
        int dn_cnt;
        //          k  nt dly dist err done perf rd clr vld fv
        vecs[0] = '{ 4, 1, 0,  0,  0,  17,  16,  4, 1,  1, 16};
        vecs[1] = '{ 0, 1, 0,  0,  1,   1,   0,  0, 0,  0, -1};
        vecs[2] = '{ 3, 3, 0,  0,  0,  46,  45,  9, 3,  3, 15};
        vecs[3] = '{17, 1, 0,  0,  1,   1,   0,  0, 0,  0, -1};
        vecs[4] = '{ 2, 2, 5,  0,  0,  39,  38,  4, 2, 12, 14};
        vecs[5] = '{ 4, 0, 0,  0,  1,   1,   0,  0, 0,  0, -1};
        vecs[6] = '{16, 1, 0,  0,  0,  29,  28, 16, 1,  1, 28};
        vecs[7] = '{ 1, 2, 0,  0,  0,  27,  26,  2, 2,  2, 13};
        vecs[8] = '{ 4, 1, 0,  8,  0,  17,  16,  4, 1,  1, 16};
        vecs[9] = '{ 4, 1, 0, 16,  0,  17,  16,  4, 1,  1, 16};

        rst = 1'b1; start = 1'b0; k_len = '0; num_tiles = '0; res_ready = 1'b0;
        tick(); tick(); tick();
        chk("reset_outputs", -1, outs_active(), 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", -1, outs_active(), 0);

        // Back-to-back commands: each start lands in the done cycle of the previous one.
        for (int i = 0; i < 10; i++) run_cmd(vecs[i], i);

        // Reset while streaming beat 2 aborts without a done pulse.
        start = 1'b1; k_len = KW'(4); num_tiles = TILE_W'(1);
        tick();
        start = 1'b0;
        tick(); tick();
        chk("feed_beat2_en",   -1, int'(op_rd_en),   1);
        chk("feed_beat2_addr", -1, int'(op_rd_addr), 2);
        rst = 1'b1;
        tick();
        chk("rst_abort_outputs", -1, outs_active(), 0);
        rst = 1'b0;
        dn_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy) dn_cnt++;
        end
        chk("no_done_after_abort", -1, dn_cnt, 0);
        run_cmd(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_tile_sched.md
Name: systolic_tile_sched

Overview:
- Tile-level sequencer for the systolic array datapath.
- Per tile: reads K operand beats from the A and B operand buffers and drives the array's en/clr so each tile starts with a fresh accumulation (clr on first beat).
- After feeding, waits a fixed drain latency, then offers the finished tile to a downstream result sink via a valid/ready handshake.
- Sits between the host command interface, the operand SRAMs and the array.

Parameters:
- ROWS, 64, array rows; used only for the drain constant.
- COLS, 64, array columns; used only for the drain constant.
- PIPE_LAT, 3, PE pipeline latency; used only for the drain constant.
- K_MAX, 256, maximum reduction depth per tile; also the address stride between tiles.
- TILE_W, 8, width of the tile count and index.
- ADDR_W, 16, operand buffer address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  command pulse; sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  reduction depth per tile; latched on accepted start
- num_tiles  in  TILE_W  tiles to process; latched on accepted start
- op_rd_en  out  1  read strobe, shared by A and B buffers
- op_rd_addr  out  ADDR_W  read address, shared by A and B buffers
- array_en  out  1  to array en
- array_clr  out  1  to array clr
- res_valid  out  1  tile result held in array is ready
- res_ready  in  1  sink has captured output_matrix
- tile_idx  out  TILE_W  index of the current tile
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at command completion
- cfg_err  out  1  one-cycle pulse when the command is rejected
- perf_cycles  out  32  busy cycles of the last or current command

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-command aborts the command; no done pulse is issued.
- Drain constant: DRAIN_LAT = ROWS + COLS + PIPE_LAT.
- Operand buffer read latency is exactly 1 cycle:
  - array_en = op_rd_en registered once.
  - array_clr = (op_rd_en & beat==0) registered once.
- op_rd_addr = tile_idx*K_MAX + beat, truncated to ADDR_W bits.
- States:
  - IDLE: start=1 latches k_len and num_tiles, clears perf_cycles and tile_idx.
    - If k_len==0, k_len>K_MAX or num_tiles==0: cfg_err and done pulse together on the next cycle; remain IDLE; no op_rd_en.
    - Otherwise go to FEED.
  - FEED: op_rd_en=1 for exactly k_len consecutive cycles; beat counts 0..k_len-1. On the last beat go to DRAIN with drain counter = DRAIN_LAT.
  - DRAIN: the counter decrements each cycle. res_valid rises on the cycle that is DRAIN_LAT cycles after the last array_en=1 cycle; go to WAIT_OUT.
  - WAIT_OUT: res_valid is held high until res_ready=1, with no en activity.
    - On handshake: if tile_idx==num_tiles-1, go to IDLE and pulse done.
    - Otherwise increment tile_idx and go to FEED on the next cycle.
- res_ready while res_valid=0 is ignored.
- start while busy is ignored; no queuing.
- perf_cycles increments every busy cycle and saturates at 2^32-1. It holds its value in IDLE until the next accepted start.
- Simultaneous events:
  - Handshake on the final tile and a start in the same cycle: start is ignored, because the block is not yet IDLE.
  - A start in the cycle after the done pulse is accepted.

Decomposition:
- Package systolic_pkg:
  - sched_state_e enum (IDLE, FEED, DRAIN, WAIT_OUT);
  - function drain_lat(rows, cols, pipe_lat).
- Shared with the array-level testbench.
- One sub-module: sched_beat_ctr, the loadable down-counter used for both the beat and drain counts, with zero and terminal flags.
- The one-cycle read-latency alignment register stays inline.

Test Plan (ROWS=COLS=4, PIPE_LAT=3, K_MAX=16, DRAIN_LAT=11):
- start, k_len=4, num_tiles=1, res_ready tied 1 ->
  - op_rd_addr 0,1,2,3 on cycles 1-4;
  - array_en high on cycles 2-5, array_clr only on cycle 2;
  - res_valid on cycle 16; done on cycle 17.
- k_len=3, num_tiles=3 ->
  - tile base addresses 0, 16, 32;
  - array_clr exactly once per tile;
  - tile_idx 0→1→2; a single done pulse.
- res_ready held low 5 cycles after res_valid -> res_valid stays high, no new op_rd_en, perf_cycles keeps counting; tile advances on the first res_ready.
- k_len=0, then k_len=17, then num_tiles=0 -> each gives cfg_err and done on the next cycle, busy never asserts, no op_rd_en.
- rst during FEED beat 2 -> next cycle all outputs 0, state IDLE; a fresh start completes normally.
- start pulsed during DRAIN -> ignored; the command finishes unchanged.
